// File: rtl/data_bus_map.sv
// Address map, status layout and decode helpers for the CPU data bus.
// Shared with CPU test programs so software and hardware agree on the map.
package data_bus_map;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned RAM_BYTES = 240;

  localparam logic [ADDR_W-1:0] ADDR_RAM_TOP = 8'hEF;
  localparam logic [ADDR_W-1:0] ADDR_LED     = 8'hF0;
  localparam logic [ADDR_W-1:0] ADDR_SW      = 8'hF1;
  localparam logic [ADDR_W-1:0] ADDR_TIMER   = 8'hF2;
  localparam logic [ADDR_W-1:0] ADDR_TX      = 8'hF4;
  localparam logic [ADDR_W-1:0] ADDR_STATUS  = 8'hF5;
  localparam logic [ADDR_W-1:0] ADDR_RX      = 8'hF6;

  localparam int unsigned ST_TX_FULL  = 0;
  localparam int unsigned ST_TX_EMPTY = 1;
  localparam int unsigned ST_RX_AVAIL = 2;
  localparam int unsigned ST_TX_OVF   = 3;

  // Status register layout as seen by the CPU at ADDR_STATUS.
  typedef struct packed {
    logic [3:0] rsvd;
    logic       tx_ovf;
    logic       rx_avail;
    logic       tx_empty;
    logic       tx_full;
  } status_t;

  // True when the address falls inside the RAM window.
  function automatic logic is_ram(input logic [ADDR_W-1:0] addr);
    return addr <= ADDR_RAM_TOP;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags.
// Push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop & ~r_empty;
  assign w_do_push = i_push & (~r_full | w_do_pop);

  // Occupancy after this cycle's accepted push/pop.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers and flags; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage is not reset; pointer reset is enough to discard contents.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/data_bus.sv
// CPU data-side memory system: 240-byte RAM plus memory-mapped LED, switches,
// timer, UART TX FIFO and RX holding register. Load data is combinational.
// Optional timer enabled by defining DATA_BUS_TIMER_EN.
module data_bus
  import data_bus_map::*;
#(
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned PRESCALE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       write,
  input  logic       read,
  input  logic [7:0] address,
  input  logic [7:0] dout,
  output logic [7:0] din,
  input  logic [7:0] sw,
  output logic [7:0] led,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);

  logic [7:0] r_ram [RAM_BYTES];
  logic [7:0] r_led;
  logic [7:0] r_sw_meta;
  logic [7:0] r_sw_sync;
  logic       r_tx_ovf;
  logic       r_rx_held;
  logic [7:0] r_rx_byte;
  logic [7:0] w_timer_val;
  logic       w_wr_ram;
  logic       w_wr_led;
  logic       w_wr_tx;
  logic       w_wr_status;
  logic       w_rd_rx;
  logic       w_tx_full;
  logic       w_tx_empty;
  logic       w_tx_pop;
  status_t    w_status;

  assign w_wr_ram    = write & is_ram(address);
  assign w_wr_led    = write & (address == ADDR_LED);
  assign w_wr_tx     = write & (address == ADDR_TX);
  assign w_wr_status = write & (address == ADDR_STATUS);
  // A simultaneous write wins; the RX pop side effect is suppressed.
  assign w_rd_rx     = read & ~write & (address == ADDR_RX);

  // RAM storage, never reset so contents survive a bus reset.
  always_ff @(posedge clk) begin
    if (w_wr_ram) r_ram[address] <= dout;
  end

  // LED register.
  always_ff @(posedge clk) begin
    if (rst)           r_led <= 8'h00;
    else if (w_wr_led) r_led <= dout;
  end

  // Two-flop synchroniser for the asynchronous switches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_meta <= 8'h00;
      r_sw_sync <= 8'h00;
    end else begin
      r_sw_meta <= sw;
      r_sw_sync <= r_sw_meta;
    end
  end

`ifdef DATA_BUS_TIMER_EN
  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] r_presc;
  logic [7:0]      r_timer;
  logic            w_wr_timer;

  assign w_wr_timer = write & (address == ADDR_TIMER);

  // Prescaled timer; a CPU write clears both stages and beats the increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_timer <= 8'h00;
    end else if (w_wr_timer) begin
      r_presc <= '0;
      r_timer <= 8'h00;
    end else if (r_presc == PS_LAST) begin
      r_presc <= '0;
      r_timer <= r_timer + 8'd1;
    end else begin
      r_presc <= r_presc + PS_W'(1);
    end
  end

  assign w_timer_val = r_timer;
`else
  logic w_unused_prescale;

  assign w_unused_prescale = (PRESCALE != 0);
  assign w_timer_val       = 8'h00;
`endif

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_wr_tx),
    .i_data  (dout),
    .i_pop   (w_tx_pop),
    .o_data  (tx_data),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  assign tx_valid = ~w_tx_empty;
  assign w_tx_pop = tx_valid & tx_ready;

  // Sticky overflow: a push dropped because the FIFO was full and not draining.
  always_ff @(posedge clk) begin
    if (rst)                                  r_tx_ovf <= 1'b0;
    else if (w_wr_status)                     r_tx_ovf <= 1'b0;
    else if (w_wr_tx & w_tx_full & ~w_tx_pop) r_tx_ovf <= 1'b1;
  end

  // One-entry RX holding register; a pop blocks capture for that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_held <= 1'b0;
      r_rx_byte <= 8'h00;
    end else if (w_rd_rx & r_rx_held) begin
      r_rx_held <= 1'b0;
    end else if (rx_valid & ~r_rx_held) begin
      r_rx_held <= 1'b1;
      r_rx_byte <= rx_data;
    end
  end

  assign rx_ready = ~r_rx_held;
  assign led      = r_led;

  // Status register assembly.
  always_comb begin
    w_status          = '0;
    w_status.tx_full  = w_tx_full;
    w_status.tx_empty = w_tx_empty;
    w_status.rx_avail = r_rx_held;
    w_status.tx_ovf   = r_tx_ovf;
  end

  // Combinational load-data decode.
  always_comb begin
    din = 8'h00;
    if (is_ram(address)) begin
      din = r_ram[address];
    end else begin
      case (address)
        ADDR_LED:    din = r_led;
        ADDR_SW:     din = r_sw_sync;
        ADDR_TIMER:  din = w_timer_val;
        ADDR_STATUS: din = w_status;
        ADDR_RX:     din = r_rx_held ? r_rx_byte : 8'h00;
        default:     din = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus.sv
// Directed bench for data_bus: RAM, LED, switches, TX FIFO, RX register, timer.
module tb_data_bus;

  logic       clk;
  logic       rst;
  logic       write;
  logic       read;
  logic [7:0] address;
  logic [7:0] dout;
  logic [7:0] din;
  logic [7:0] sw;
  logic [7:0] led;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  int n_checks = 0;
  int n_errors = 0;

  data_bus #(
    .TX_DEPTH (4),
    .PRESCALE (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .write    (write),
    .read     (read),
    .address  (address),
    .dout     (dout),
    .din      (din),
    .sw       (sw),
    .led      (led),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    address = a;
    dout    = d;
    write   = 1'b1;
    step();
    write   = 1'b0;
  endtask

  task automatic look(input logic [7:0] a);
    address = a;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_checks++;
    if (led !== 8'h00) begin n_errors++; $display("FAIL rst_led: got %h exp 00", led); end
    n_checks++;
    if (tx_valid !== 1'b0) begin n_errors++; $display("FAIL rst_tx_valid: got %b exp 0", tx_valid); end
    n_checks++;
    if (rx_ready !== 1'b1) begin n_errors++; $display("FAIL rst_rx_ready: got %b exp 1", rx_ready); end
    look(8'hF5);
    n_checks++;
    if (din !== 8'h02) begin n_errors++; $display("FAIL rst_status: got %h exp 02", din); end
    look(8'hF2);
    n_checks++;
    if (din !== 8'h00) begin n_errors++; $display("FAIL rst_timer: got %h exp 00", din); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_ram();
    bus_write(8'h10, 8'h5A);
    read = 1'b1;
    look(8'h10);
    n_checks++;
    if (din !== 8'h5A) begin n_errors++; $display("FAIL ram_rd10: got %h exp 5a", din); end
    look(8'hF9);
    n_checks++;
    if (din !== 8'h00) begin n_errors++; $display("FAIL unmapped_f9: got %h exp 00", din); end
    read = 1'b0;
    bus_write(8'hEF, 8'hC3);
    bus_write(8'hF3, 8'h77);
    look(8'hEF);
    n_checks++;
    if (din !== 8'hC3) begin n_errors++; $display("FAIL ram_top: got %h exp c3", din); end
    look(8'hF3);
    n_checks++;
    if (din !== 8'h00) begin n_errors++; $display("FAIL unmapped_f3: got %h exp 00", din); end
    // Strobe low: address and data present but no write.
    address = 8'h10; dout = 8'hFF; step();
    look(8'h10);
    n_checks++;
    if (din !== 8'h5A) begin n_errors++; $display("FAIL ram_nostrobe: got %h exp 5a", din); end
  endtask

  task automatic test_led();
    bus_write(8'hF0, 8'hA5);
    n_checks++;
    if (led !== 8'hA5) begin n_errors++; $display("FAIL led_wr: got %h exp a5", led); end
    look(8'hF0);
    n_checks++;
    if (din !== 8'hA5) begin n_errors++; $display("FAIL led_rd: got %h exp a5", din); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (led !== 8'h00) begin n_errors++; $display("FAIL led_rst: got %h exp 00", led); end
    look(8'h10);
    n_checks++;
    if (din !== 8'h5A) begin n_errors++; $display("FAIL ram_keep: got %h exp 5a", din); end
  endtask

  task automatic test_tx_overflow();
    tx_ready = 1'b0;
    for (int i = 1; i <= 4; i++) bus_write(8'hF4, 8'(i));
    look(8'hF5);
    n_checks++;
    if (din !== 8'h01) begin n_errors++; $display("FAIL tx_full_st: got %h exp 01", din); end
    bus_write(8'hF4, 8'h05);
    look(8'hF5);
    n_checks++;
    if (din !== 8'h09) begin n_errors++; $display("FAIL tx_ovf_st: got %h exp 09", din); end
    step();
    n_checks++;
    if (tx_data !== 8'h01 || tx_valid !== 1'b1) begin
      n_errors++; $display("FAIL tx_hold: got %h/%b exp 01/1", tx_data, tx_valid);
    end
    tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_checks++;
      if (tx_data !== 8'(i) || tx_valid !== 1'b1) begin
        n_errors++; $display("FAIL tx_order%0d: got %h/%b exp %h/1", i, tx_data, tx_valid, 8'(i));
      end
      step();
    end
    n_checks++;
    if (tx_valid !== 1'b0) begin n_errors++; $display("FAIL tx_drained: got %b exp 0", tx_valid); end
    tx_ready = 1'b0;
    look(8'hF5);
    n_checks++;
    if (din !== 8'h0A) begin n_errors++; $display("FAIL tx_ovf_sticky: got %h exp 0a", din); end
    bus_write(8'hF5, 8'h00);
    look(8'hF5);
    n_checks++;
    if (din !== 8'h02) begin n_errors++; $display("FAIL tx_ovf_clr: got %h exp 02", din); end
  endtask

  task automatic test_tx_full_pop();
    logic [7:0] exp_q [4];
    exp_q = '{8'h12, 8'h13, 8'h14, 8'h15};
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) bus_write(8'hF4, 8'(8'h11 + i));
    tx_ready = 1'b1;
    bus_write(8'hF4, 8'h15);
    look(8'hF5);
    n_checks++;
    if (din !== 8'h01) begin n_errors++; $display("FAIL tx_fullpop_st: got %h exp 01", din); end
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (tx_data !== exp_q[i] || tx_valid !== 1'b1) begin
        n_errors++; $display("FAIL tx_fullpop%0d: got %h/%b exp %h/1", i, tx_data, tx_valid, exp_q[i]);
      end
      step();
    end
    tx_ready = 1'b0;
    look(8'hF5);
    n_checks++;
    if (din !== 8'h02) begin n_errors++; $display("FAIL tx_fullpop_end: got %h exp 02", din); end
  endtask

  task automatic test_rx();
    rx_data = 8'h3C; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
    n_checks++;
    if (rx_ready !== 1'b0) begin n_errors++; $display("FAIL rx_cap_rdy: got %b exp 0", rx_ready); end
    look(8'hF5);
    n_checks++;
    if (din !== 8'h06) begin n_errors++; $display("FAIL rx_cap_st: got %h exp 06", din); end
    read = 1'b1;
    look(8'hF6);
    n_checks++;
    if (din !== 8'h3C) begin n_errors++; $display("FAIL rx_rd: got %h exp 3c", din); end
    step();
    read = 1'b0;
    n_checks++;
    if (rx_ready !== 1'b1) begin n_errors++; $display("FAIL rx_pop_rdy: got %b exp 1", rx_ready); end
    look(8'hF5);
    n_checks++;
    if (din !== 8'h02) begin n_errors++; $display("FAIL rx_pop_st: got %h exp 02", din); end
    // Pop and new byte in the same cycle: capture slips one cycle.
    rx_data = 8'h44; rx_valid = 1'b1;
    step();
    rx_data = 8'h55;
    address = 8'hF6; read = 1'b1;
    step();
    read = 1'b0;
    n_checks++;
    if (rx_ready !== 1'b1) begin n_errors++; $display("FAIL rx_blocked: got %b exp 1", rx_ready); end
    step();
    rx_valid = 1'b0;
    look(8'hF6);
    n_checks++;
    if (din !== 8'h55 || rx_ready !== 1'b0) begin
      n_errors++; $display("FAIL rx_late_cap: got %h/%b exp 55/0", din, rx_ready);
    end
    // read=0 at 0xF6 must not pop.
    step();
    n_checks++;
    if (rx_ready !== 1'b0) begin n_errors++; $display("FAIL rx_noread: got %b exp 0", rx_ready); end
  endtask

  task automatic test_strobe_both();
    address = 8'hF6; dout = 8'h99; write = 1'b1; read = 1'b1;
    step();
    write = 1'b0; read = 1'b0;
    look(8'hF6);
    n_checks++;
    if (din !== 8'h55 || rx_ready !== 1'b0) begin
      n_errors++; $display("FAIL rw_nopop: got %h/%b exp 55/0", din, rx_ready);
    end
    address = 8'hF6; read = 1'b1;
    step();
    read = 1'b0;
  endtask

  task automatic test_sw();
    sw = 8'h81;
    look(8'hF1);
    n_checks++;
    if (din !== 8'h00) begin n_errors++; $display("FAIL sw_c0: got %h exp 00", din); end
    step();
    n_checks++;
    if (din !== 8'h00) begin n_errors++; $display("FAIL sw_c1: got %h exp 00", din); end
    step();
    n_checks++;
    if (din !== 8'h81) begin n_errors++; $display("FAIL sw_c2: got %h exp 81", din); end
    bus_write(8'hF1, 8'h00);
    look(8'hF1);
    n_checks++;
    if (din !== 8'h81) begin n_errors++; $display("FAIL sw_ro: got %h exp 81", din); end
  endtask

`ifdef DATA_BUS_TIMER_EN
  task automatic test_timer();
    rst = 1'b1;
    step();
    rst = 1'b0;
    address = 8'hF2;
    repeat (48) step();
    n_checks++;
    if (din !== 8'h03) begin n_errors++; $display("FAIL tmr_48: got %h exp 03", din); end
    repeat (15) step();
    bus_write(8'hF2, 8'h00);
    look(8'hF2);
    n_checks++;
    if (din !== 8'h00) begin n_errors++; $display("FAIL tmr_clr_inc: got %h exp 00", din); end
    repeat (15) step();
    n_checks++;
    if (din !== 8'h00) begin n_errors++; $display("FAIL tmr_presc_clr: got %h exp 00", din); end
    step();
    n_checks++;
    if (din !== 8'h01) begin n_errors++; $display("FAIL tmr_after_clr: got %h exp 01", din); end
    repeat (254 * 16) step();
    n_checks++;
    if (din !== 8'hFF) begin n_errors++; $display("FAIL tmr_ff: got %h exp ff", din); end
    repeat (16) step();
    n_checks++;
    if (din !== 8'h00) begin n_errors++; $display("FAIL tmr_wrap: got %h exp 00", din); end
  endtask
`else
  task automatic test_timer();
    bus_write(8'hF2, 8'h55);
    address = 8'hF2;
    repeat (40) step();
    n_checks++;
    if (din !== 8'h00) begin n_errors++; $display("FAIL tmr_absent: got %h exp 00", din); end
  endtask
`endif

  initial begin
    rst = 1'b1; write = 1'b0; read = 1'b0; address = 8'h00; dout = 8'h00;
    sw = 8'h00; tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    test_reset();
    test_ram();
    test_led();
    test_tx_overflow();
    test_tx_full_pop();
    test_rx();
    test_strobe_both();
    test_sw();
    test_timer();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
